// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared widths, constants and enums for the two-requester BRAM arbiter
package bram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  // Reserved word that soaks up the idle writes of the always-write-enabled macro
  localparam logic [ADDR_W-1:0] PARK_ADDR = 8'hFF;

  // 32-bit read/write mode, write port permanently enabled
  localparam logic [7:0] BRAM_CFG = 8'b0001_0000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/bram_arbiter2_if.sv
// rtl/bram_arbiter2_if.sv - requester A/B handshakes and BRAM macro pins of the arbiter
interface bram_arbiter2_if;
  import bram_arb_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_valid;
  logic              b_ready;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] bram_rd_addr;
  logic [ADDR_W-1:0] bram_wr_addr;
  logic [DATA_W-1:0] bram_wr_data;
  logic [DATA_W-1:0] bram_rd_data;
  logic [7:0]        bram_config;
  logic              init_done;

  // Arbiter side
  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    input  b_valid, b_we, b_addr, b_wdata,
    input  bram_rd_data,
    output a_ready, a_rvalid, a_rdata,
    output b_ready, b_rvalid, b_rdata,
    output bram_rd_addr, bram_wr_addr, bram_wr_data, bram_config, init_done
  );

  // User logic plus macro side
  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    output b_valid, b_we, b_addr, b_wdata,
    output bram_rd_data,
    input  a_ready, a_rvalid, a_rdata,
    input  b_ready, b_rvalid, b_rdata,
    input  bram_rd_addr, bram_wr_addr, bram_wr_data, bram_config, init_done
  );

endinterface

// File: rtl/bram_arbiter2_rr_arb2.sv
// rtl/bram_arbiter2_rr_arb2.sv - two-way round-robin grant with a single priority flop
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  req_id_e prio_q;

  // Grant follows valid combinationally; the favoured side wins a tie
  always_comb begin
    grant = 2'b00;
    if (en) begin
      grant[0] = valid[0] & ((prio_q == REQ_A) | ~valid[1]);
      grant[1] = valid[1] & ((prio_q == REQ_B) | ~valid[0]);
    end
  end

  // Hand priority to the other side after each grant, hold it on idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= REQ_A;
    end else if (grant[0]) begin
      prio_q <= REQ_B;
    end else if (grant[1]) begin
      prio_q <= REQ_A;
    end
  end

endmodule

// File: rtl/bram_arbiter2.sv
// rtl/bram_arbiter2.sv - BRAM scheduler for two requesters; BRAM_ARB_FWD_EN enables write-to-read bypass
module bram_arbiter2 #(
  parameter logic [bram_arb_pkg::ADDR_W-1:0] PARK_ADDR      = bram_arb_pkg::PARK_ADDR,
  parameter logic [7:0]                      BRAM_CFG       = bram_arb_pkg::BRAM_CFG,
  parameter bit                              CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  bram_arbiter2_if.slave  bus
);
  import bram_arb_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] clr_ctr_q;
  logic              run;

  logic [1:0]        grant;
  logic              sel_b;
  logic              g_any;
  logic              g_we;
  logic              g_wr;
  logic              g_rd;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  logic              rvalid_q;
  req_id_e           rid_q;
  logic [DATA_W-1:0] ret_data;

  assign run = (state_q == ST_RUN);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .valid ({bus.b_valid, bus.a_valid}),
    .grant (grant)
  );

  // State register; reset lands in the clear sweep unless it is disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave the sweep once the last word has been written
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_CLEAR) && (clr_ctr_q == '1)) begin
      state_d = ST_RUN;
    end
  end

  // Sweep address counter, advances only while clearing
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ctr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_ctr_q <= clr_ctr_q + ADDR_W'(1);
    end
  end

  // Mux the granted request into a single access description
  always_comb begin
    sel_b   = grant[1];
    g_any   = grant[0] | grant[1];
    g_we    = sel_b ? bus.b_we    : bus.a_we;
    g_addr  = sel_b ? bus.b_addr  : bus.a_addr;
    g_wdata = sel_b ? bus.b_wdata : bus.a_wdata;
    g_wr    = g_any & g_we;
    g_rd    = g_any & ~g_we;
  end

  // Drive handshakes and macro pins; unused ports sit on the park word
  always_comb begin
    bus.a_ready      = grant[0];
    bus.b_ready      = grant[1];
    bus.init_done    = run;
    bus.bram_config  = BRAM_CFG;
    bus.bram_wr_addr = PARK_ADDR;
    bus.bram_wr_data = '0;
    bus.bram_rd_addr = PARK_ADDR;
    if (state_q == ST_CLEAR) begin
      bus.bram_wr_addr = clr_ctr_q;
    end else if (g_wr) begin
      bus.bram_wr_addr = g_addr;
      bus.bram_wr_data = g_wdata;
    end
    if (g_rd) begin
      bus.bram_rd_addr = g_addr;
    end
  end

  // Remember who owns the read in flight; reset drops it
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rid_q    <= REQ_A;
    end else begin
      rvalid_q <= g_rd;
      if (g_rd) begin
        rid_q <= sel_b ? REQ_B : REQ_A;
      end
    end
  end

`ifdef BRAM_ARB_FWD_EN
  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;

  // Track the previous cycle's write so a read right behind it sees the new word
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_q  <= 1'b0;
      fwd_hit_q <= 1'b0;
    end else begin
      wr_vld_q  <= g_wr;
      fwd_hit_q <= g_rd & wr_vld_q & (g_addr == wr_addr_q);
    end
    wr_addr_q  <= g_addr;
    wr_data_q  <= g_wdata;
    fwd_data_q <= wr_data_q;
  end

  assign ret_data = fwd_hit_q ? fwd_data_q : bus.bram_rd_data;
`else
  assign ret_data = bus.bram_rd_data;
`endif

  // Steer returning data to its owner, zero when not valid
  always_comb begin
    bus.a_rvalid = rvalid_q & (rid_q == REQ_A);
    bus.b_rvalid = rvalid_q & (rid_q == REQ_B);
    bus.a_rdata  = bus.a_rvalid ? ret_data : '0;
    bus.b_rdata  = bus.b_rvalid ? ret_data : '0;
  end

endmodule

// File: tb/tb_bram_arbiter2.sv
// tb/tb_bram_arbiter2.sv - self-checking bench for bram_arbiter2 with BRAM macro model and reference model
module tb_bram_arbiter2;
  import bram_arb_pkg::*;

`ifdef BRAM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_arbiter2_if bus();

  bram_arbiter2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Macro model: read data one cycle after address, writes land one cycle late
  logic [31:0] bram_mem [256];
  logic        stg_v;
  logic [7:0]  stg_a;
  logic [31:0] stg_d;

  initial begin
    for (int i = 0; i < 256; i++) bram_mem[i] = 32'hBAD0_0000 | i;
    stg_v = 1'b0;
    stg_a = 8'h00;
    stg_d = 32'h0;
    bus.bram_rd_data = 32'h0;
    forever begin
      @(posedge clk);
      bus.bram_rd_data <= bram_mem[bus.bram_rd_addr];
      if (stg_v) bram_mem[stg_a] <= stg_d;
      stg_v <= 1'b1;
      stg_a <= bus.bram_wr_addr;
      stg_d <= bus.bram_wr_data;
    end
  end

  typedef struct {
    logic        rst;
    logic        av;
    logic        aw;
    logic [7:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic        bw;
    logic [7:0]  ba;
    logic [31:0] bd;
  } cyc_t;

  typedef struct {
    logic av;
    logic bv;
    logic exp_ar;
    logic exp_br;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  int          m_clr;
  logic [7:0]  m_clr_idx;
  logic        m_prio;
  logic        m_pv;
  logic        m_pid;
  logic [31:0] m_pdata;
  logic        m_wv;
  logic [7:0]  m_wa;
  logic [31:0] m_wd;

  // Snapshot of the last checked cycle
  logic        s_ar, s_br, s_arv, s_brv, s_init;
  logic [31:0] s_ard, s_brd;
  logic [7:0]  s_wa;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    m_clr     = 256;
    m_clr_idx = 8'h00;
    m_prio    = 1'b0;
    m_pv      = 1'b0;
    m_pid     = 1'b0;
    m_pdata   = 32'h0;
    m_wv      = 1'b0;
    m_wa      = 8'h00;
    m_wd      = 32'h0;
  endtask

  function automatic cyc_t c_idle();
    cyc_t c;
    c.rst = 1'b0; c.av = 1'b0; c.aw = 1'b0; c.aa = 8'h00; c.ad = 32'h0;
    c.bv = 1'b0; c.bw = 1'b0; c.ba = 8'h00; c.bd = 32'h0;
    return c;
  endfunction

  function automatic cyc_t c_op(input logic to_b, input logic we, input logic [7:0] addr, input logic [31:0] data);
    cyc_t c;
    c = c_idle();
    if (!to_b) begin
      c.av = 1'b1; c.aw = we; c.aa = addr; c.ad = data;
    end else begin
      c.bv = 1'b1; c.bw = we; c.ba = addr; c.bd = data;
    end
    return c;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance the model after the edge
  task automatic cycle(input cyc_t c);
    logic        run, ga, gb, gwr, grd, exp_arv, exp_brv;
    logic [7:0]  ea, exp_wa, exp_ra;
    logic [31:0] ed, exp_wd;
    rst         = c.rst;
    bus.a_valid = c.av; bus.a_we = c.aw; bus.a_addr = c.aa; bus.a_wdata = c.ad;
    bus.b_valid = c.bv; bus.b_we = c.bw; bus.b_addr = c.ba; bus.b_wdata = c.bd;
    @(negedge clk);
    run = (m_clr == 0);
    ga = 1'b0;
    gb = 1'b0;
    if (run) begin
      if (c.av && c.bv) begin
        ga = ~m_prio;
        gb = m_prio;
      end else begin
        ga = c.av;
        gb = c.bv;
      end
    end
    ea      = gb ? c.ba : c.aa;
    ed      = gb ? c.bd : c.ad;
    gwr     = (ga & c.aw) | (gb & c.bw);
    grd     = (ga | gb) & ~gwr;
    exp_wa  = !run ? m_clr_idx : (gwr ? ea : 8'hFF);
    exp_wd  = gwr ? ed : 32'h0;
    exp_ra  = grd ? ea : 8'hFF;
    exp_arv = m_pv & ~m_pid;
    exp_brv = m_pv & m_pid;
    chk("a_ready",      32'(bus.a_ready),      32'(ga));
    chk("b_ready",      32'(bus.b_ready),      32'(gb));
    chk("init_done",    32'(bus.init_done),    32'(run));
    chk("bram_wr_addr", 32'(bus.bram_wr_addr), 32'(exp_wa));
    chk("bram_wr_data", bus.bram_wr_data,      exp_wd);
    chk("bram_rd_addr", 32'(bus.bram_rd_addr), 32'(exp_ra));
    chk("bram_config",  32'(bus.bram_config),  32'h10);
    chk("a_rvalid",     32'(bus.a_rvalid),     32'(exp_arv));
    chk("a_rdata",      bus.a_rdata,           exp_arv ? m_pdata : 32'h0);
    chk("b_rvalid",     32'(bus.b_rvalid),     32'(exp_brv));
    chk("b_rdata",      bus.b_rdata,           exp_brv ? m_pdata : 32'h0);
    s_ar = bus.a_ready;  s_br = bus.b_ready;
    s_arv = bus.a_rvalid; s_brv = bus.b_rvalid;
    s_ard = bus.a_rdata; s_brd = bus.b_rdata;
    s_init = bus.init_done; s_wa = bus.bram_wr_addr;
    @(posedge clk);
    #1;
    if (c.rst) begin
      m_reset();
    end else begin
      if (!run) begin
        m_clr--;
        m_clr_idx++;
      end
      m_pv  = grd;
      m_pid = gb;
      if (grd) m_pdata = (FWD && m_wv && (m_wa == ea)) ? m_wd : m_mem[ea];
      if (m_wv) m_mem[m_wa] = m_wd;
      m_wv = gwr && (ea != 8'hFF);
      m_wa = ea;
      m_wd = ed;
      if (ga) m_prio = 1'b1;
      else if (gb) m_prio = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vec_t tbl [15];
    cyc_t c;
    int   n_clear, rdy_in_clear, nz, rv_cnt, ga_cnt, gb_cnt;

    tbl = '{
      '{1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0}
    };

    c = c_idle();
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_addr = 8'h00; bus.a_wdata = 32'h0;
    bus.b_valid = 1'b0; bus.b_we = 1'b0; bus.b_addr = 8'h00; bus.b_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    m_reset();

    // Clear sweep: A keeps requesting, must not be served until init_done
    n_clear = 0;
    rdy_in_clear = 0;
    for (int k = 0; k < 400; k++) begin
      cycle(c_op(1'b0, 1'b0, 8'h05, 32'h0));
      if (s_init) break;
      n_clear++;
      if (s_ar) rdy_in_clear++;
    end
    chk("clear_cycles", 32'(n_clear), 32'd256);
    chk("ready_in_clear", 32'(rdy_in_clear), 32'd0);
    cycle(c_idle());

    // Every address except the park word reads back zero
    nz = 0;
    rv_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      if (k < 255) cycle(c_op(1'b0, 1'b0, 8'(k), 32'h0));
      else cycle(c_idle());
      if (s_arv) rv_cnt++;
      if (s_arv && (s_ard != 32'h0)) nz++;
    end
    chk("clear_read_count", 32'(rv_cnt), 32'd255);
    chk("clear_nonzero", 32'(nz), 32'd0);

    // A write, gap, A read
    cycle(c_op(1'b0, 1'b1, 8'h10, 32'hDEADBEEF));
    cycle(c_idle());
    cycle(c_op(1'b0, 1'b0, 8'h10, 32'h0));
    chk("t2_grant", 32'(s_ar), 32'd1);
    cycle(c_idle());
    chk("t2_a_rvalid", 32'(s_arv), 32'd1);
    chk("t2_a_rdata", s_ard, 32'hDEADBEEF);
    chk("t2_b_rvalid", 32'(s_brv), 32'd0);

    // Single B grant hands priority back to A before the table
    cycle(c_op(1'b1, 1'b1, 8'h30, 32'h0000_0030));

    ga_cnt = 0;
    gb_cnt = 0;
    for (int r = 0; r < 15; r++) begin
      c = c_idle();
      c.av = tbl[r].av; c.aw = 1'b1; c.aa = 8'(8'h40 + r); c.ad = 32'hA000_0000 + r;
      c.bv = tbl[r].bv; c.bw = 1'b1; c.ba = 8'(8'h60 + r); c.bd = 32'hB000_0000 + r;
      cycle(c);
      chk($sformatf("tbl%0d_a_ready", r), 32'(s_ar), 32'(tbl[r].exp_ar));
      chk($sformatf("tbl%0d_b_ready", r), 32'(s_br), 32'(tbl[r].exp_br));
      if (r < 8) begin
        if (s_ar) ga_cnt++;
        if (s_br) gb_cnt++;
      end
    end
    chk("a_grants_of_8", 32'(ga_cnt), 32'd4);
    chk("b_grants_of_8", 32'(gb_cnt), 32'd4);

    // B streams 8 reads after writing 0x100+i
    for (int i = 0; i < 8; i++) cycle(c_op(1'b1, 1'b1, 8'(i), 32'h100 + i));
    cycle(c_idle());
    for (int k = 0; k < 9; k++) begin
      if (k < 8) cycle(c_op(1'b1, 1'b0, 8'(k), 32'h0));
      else cycle(c_idle());
      if (k >= 1) begin
        chk($sformatf("stream%0d_b_rvalid", k - 1), 32'(s_brv), 32'd1);
        chk($sformatf("stream%0d_b_rdata", k - 1), s_brd, 32'h100 + k - 1);
      end
    end
    cycle(c_idle());
    chk("stream_end_b_rvalid", 32'(s_brv), 32'd0);

    // Read right behind a write to the same word
    cycle(c_op(1'b0, 1'b1, 8'h20, 32'h5A5A5A5A));
    if (!FWD) cycle(c_idle());
    cycle(c_op(1'b0, 1'b0, 8'h20, 32'h0));
    cycle(c_idle());
    chk("raw_a_rvalid", 32'(s_arv), 32'd1);
    chk("raw_a_rdata", s_ard, 32'h5A5A5A5A);

    // Random traffic against the model, small address range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      c = c_idle();
      c.av = 1'($urandom); c.aw = 1'($urandom);
      c.aa = 8'($urandom_range(0, 15)); c.ad = $urandom;
      c.bv = 1'($urandom); c.bw = 1'($urandom);
      c.ba = 8'($urandom_range(0, 15)); c.bd = $urandom;
      if (c.aw && ($urandom_range(0, 15) == 0)) c.aa = 8'hFF;
      if (c.bw && ($urandom_range(0, 15) == 0)) c.ba = 8'hFF;
      cycle(c);
    end
    cycle(c_idle());

    // Reset on the edge that would capture a read: response must vanish, sweep restarts
    c = c_op(1'b0, 1'b0, 8'h03, 32'h0);
    c.rst = 1'b1;
    cycle(c);
    chk("rst_read_granted", 32'(s_ar), 32'd1);
    cycle(c_idle());
    chk("rst_a_rvalid", 32'(s_arv), 32'd0);
    chk("rst_init_done", 32'(s_init), 32'd0);
    chk("rst_clr_addr0", 32'(s_wa), 32'd0);
    cycle(c_idle());
    chk("rst_clr_addr1", 32'(s_wa), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
